// File: rtl/multicore_priority_scheduler.sv
// Priority task scheduler: per-priority circular FIFOs feed a pool of cores.
// At most one task is dispatched per cycle. It goes to the lowest-indexed free
// core and is taken from the highest aged queue, or else from the highest
// non-empty queue. Each core counts its task down to completion.
module multicore_priority_scheduler #(
    parameter int NUM_CORES   = 4,
    parameter int NUM_PRIO    = 4,
    parameter int QUEUE_DEPTH = 16,
    parameter int DUR_W       = 8,
    parameter int AGE_LIMIT   = 32,
    localparam int PW = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1,
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       task_valid,
    output logic                       task_ready,
    input  logic [PW-1:0]              task_priority,
    input  logic [DUR_W-1:0]           task_duration,
    output logic                       task_drop,
    output logic [NUM_CORES-1:0]       core_busy,
    output logic [NUM_CORES-1:0]       core_done,
    output logic [NUM_CORES*DUR_W-1:0] core_time,
    output logic [NUM_PRIO-1:0]        queue_full,
    output logic [NUM_PRIO-1:0]        queue_empty,
    output logic                       dispatch_valid,
    output logic [CW-1:0]              dispatch_core,
    output logic                       dispatch_aged
);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam logic [QW:0]   DEPTH_C = (QW+1)'(QUEUE_DEPTH);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    // State
    logic [DUR_W-1:0]     mem_q [NUM_PRIO][QUEUE_DEPTH];
    logic [DUR_W-1:0]     mem_d [NUM_PRIO][QUEUE_DEPTH];
    logic [QW-1:0]        head_q [NUM_PRIO], head_d [NUM_PRIO];
    logic [QW-1:0]        tail_q [NUM_PRIO], tail_d [NUM_PRIO];
    logic [QW:0]          count_q [NUM_PRIO], count_d [NUM_PRIO];
    logic [AW-1:0]        age_q [NUM_PRIO], age_d [NUM_PRIO];
    logic [DUR_W-1:0]     time_q [NUM_CORES], time_d [NUM_CORES];
    logic [NUM_CORES-1:0] busy_q, busy_d, done_q, done_d;
    logic [NUM_PRIO-1:0]  full_q, full_d, empty_q, empty_d;
    logic                 drop_q, drop_d, dv_q, dv_d, da_q, da_d;
    logic [CW-1:0]        dc_q, dc_d;

    // Combinational decisions
    logic                 in_range_s, sel_full_s, enq_s, disp_s;
    logic [DUR_W-1:0]     dur_in_s;
    logic                 free_found_s, high_found_s, aged_found_s;
    logic [CW-1:0]        free_idx_s;
    logic [PW-1:0]        high_idx_s, aged_idx_s, src_idx_s;
    logic [NUM_PRIO-1:0]  push_s, pop_s;

    // Input acceptance: ready follows the registered full flag of the addressed queue
    always_comb begin
        in_range_s = (int'(task_priority) < NUM_PRIO);
        sel_full_s = 1'b0;
        for (int p = 0; p < NUM_PRIO; p++) begin
            sel_full_s = (task_priority == PW'(p)) ? full_q[p] : sel_full_s;
        end
        task_ready = in_range_s ? ~sel_full_s : 1'b1;
        enq_s      = task_valid & task_ready & in_range_s;
        dur_in_s   = (task_duration == '0) ? DUR_W'(1) : task_duration;
    end

    // Core and source-queue selection for this cycle's dispatch
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            free_found_s = free_found_s | ~busy_q[c];
            free_idx_s   = busy_q[c] ? free_idx_s : CW'(c);
        end
        high_found_s = 1'b0;
        high_idx_s   = '0;
        aged_found_s = 1'b0;
        aged_idx_s   = '0;
        for (int p = 0; p < NUM_PRIO; p++) begin
            high_found_s = high_found_s | (count_q[p] != '0);
            high_idx_s   = (count_q[p] != '0) ? PW'(p) : high_idx_s;
            if ((AGE_LIMIT != 0) && (count_q[p] != '0) && (age_q[p] >= AGE_MAX)) begin
                aged_found_s = 1'b1;
                aged_idx_s   = PW'(p);
            end else begin
                aged_idx_s   = aged_idx_s;
            end
        end
        src_idx_s = aged_found_s ? aged_idx_s : high_idx_s;
        disp_s    = free_found_s & high_found_s;
        for (int p = 0; p < NUM_PRIO; p++) begin
            push_s[p] = enq_s & (task_priority == PW'(p));
            pop_s[p]  = disp_s & (src_idx_s == PW'(p));
        end
    end

    // Next state: core countdown, dispatch, enqueue, counts, aging and flags
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        age_d   = age_q;
        time_d  = time_q;
        busy_d  = busy_q;
        done_d  = '0;
        dv_d    = disp_s;
        dc_d    = dc_q;
        da_d    = da_q;
        drop_d  = task_valid & ~in_range_s;
        full_d  = full_q;
        empty_d = empty_q;

        for (int c = 0; c < NUM_CORES; c++) begin
            if (busy_q[c]) begin
                if (time_q[c] == DUR_W'(1)) begin
                    busy_d[c] = 1'b0;
                    time_d[c] = '0;
                    done_d[c] = 1'b1;
                end else begin
                    time_d[c] = time_q[c] - DUR_W'(1);
                end
            end else begin
                time_d[c] = time_q[c];
            end
        end

        // A free core is idle, so loading it never collides with its countdown
        if (disp_s) begin
            time_d[free_idx_s] = mem_q[src_idx_s][head_q[src_idx_s]];
            busy_d[free_idx_s] = 1'b1;
            head_d[src_idx_s]  = head_q[src_idx_s] + QW'(1);
            dc_d               = free_idx_s;
            da_d               = aged_found_s;
        end else begin
            dc_d = dc_q;
            da_d = da_q;
        end

        if (enq_s) begin
            mem_d[task_priority][tail_q[task_priority]] = dur_in_s;
            tail_d[task_priority] = tail_q[task_priority] + QW'(1);
        end else begin
            tail_d = tail_q;
        end

        for (int p = 0; p < NUM_PRIO; p++) begin
            case ({push_s[p], pop_s[p]})
                2'b10:   count_d[p] = count_q[p] + (QW+1)'(1);
                2'b01:   count_d[p] = count_q[p] - (QW+1)'(1);
                default: count_d[p] = count_q[p];
            endcase
            // A non-empty queue that was not served always waits one more cycle:
            // either a different queue won the free core or no core was free.
            if ((count_q[p] == '0) || pop_s[p]) begin
                age_d[p] = '0;
            end else if (age_q[p] < AGE_MAX) begin
                age_d[p] = age_q[p] + AW'(1);
            end else begin
                age_d[p] = age_q[p];
            end
            full_d[p]  = (count_d[p] == DEPTH_C);
            empty_d[p] = (count_d[p] == '0);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PRIO; p++) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    mem_q[p][i] <= '0;
                end
                head_q[p]  <= '0;
                tail_q[p]  <= '0;
                count_q[p] <= '0;
                age_q[p]   <= '0;
            end
            for (int c = 0; c < NUM_CORES; c++) begin
                time_q[c] <= '0;
            end
            busy_q  <= '0;
            done_q  <= '0;
            full_q  <= '0;
            empty_q <= '1;
            drop_q  <= 1'b0;
            dv_q    <= 1'b0;
            dc_q    <= '0;
            da_q    <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            age_q   <= age_d;
            time_q  <= time_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            drop_q  <= drop_d;
            dv_q    <= dv_d;
            dc_q    <= dc_d;
            da_q    <= da_d;
        end
    end

    // Pack per-core remaining time onto the flat output bus
    always_comb begin
        core_time = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            core_time[c*DUR_W +: DUR_W] = time_q[c];
        end
    end

    assign core_busy      = busy_q;
    assign core_done      = done_q;
    assign queue_full     = full_q;
    assign queue_empty    = empty_q;
    assign task_drop      = drop_q;
    assign dispatch_valid = dv_q;
    assign dispatch_core  = dc_q;
    assign dispatch_aged  = da_q;

endmodule
